dtw_ref_rd_arbiter: RTL
=======================

// Module: dtw_ref_rd_arbiter
// PURPOSE
//   Shares the single reference-memory read port among NUM_REQ DTW cores.
//   Arbitration is round-robin. Each request is a valid/ready handshake.
//   Response data is returned two cycles after the grant, tagged by a one-hot valid per requester.
//   Sits between the per-core DTW engines and the ref memory port whose synchronous read has 1-cycle latency.
//   Grants only while enable_in=1, so a ref load in progress owns the memory.
// PARAMETERS
//   NUM_REQ           4   number of requesting DTW cores (2..16)
//   DATA_WIDTH        16  reference sample width
//   REFMEM_PTR_WIDTH  20  reference memory address width
//   ID_WIDTH          2   $clog2(NUM_REQ); width of grant index
// PORTS
//   clk_in         in   1                        clock (posedge)
//   rst_in         in   1                        reset, asynchronous, active-high
//   enable_in      in   1                        1 = grants allowed (ref load done, DTW read mode)
//   ref_len_in     in   REFMEM_PTR_WIDTH         valid reference length; addr >= ref_len_in is out of range
//   req_valid_in   in   NUM_REQ                  per-requester read request
//   req_addr_in    in   NUM_REQ*REFMEM_PTR_WIDTH requester i address at [i*W +: W]
//   req_ready_out  out  NUM_REQ                  one-hot grant; handshake = valid & ready
//   rsp_valid_out  out  NUM_REQ                  one-hot, 1-cycle response strobe
//   rsp_data_out   out  DATA_WIDTH               response data, shared bus
//   rsp_err_out    out  1                        response was out of range (data forced 0)
//   mem_addr_out   out  REFMEM_PTR_WIDTH         to ref memory read address
//   mem_data_in    in   DATA_WIDTH               ref memory read data (valid 1 cycle after addr)
//   busy_out       out  1                        any request pending or response in flight
//   dbg_grant_out  out  ID_WIDTH                 last granted index
// BEHAVIOUR
//   Reset: all outputs 0. Priority pointer = 0. Both pipeline stages invalid.
//     A mid-operation reset drops in-flight responses; no rsp strobe follows.
//   Grant (combinational, cycle t):
//     - Condition: enable_in=1 and some req_valid_in set.
//     - req_ready_out = one-hot of the first valid index at or after the pointer, searching circularly.
//     - Otherwise req_ready_out = 0.
//     - At most one grant per cycle. Sustained throughput is 1 request/clk.
//   Pointer: on a handshake with requester i, pointer <= (i+1) mod NUM_REQ. Otherwise it holds.
//   Stage 1 (edge ending t):
//     - mem_addr_out <= granted addr. Stage-1 valid/id/oob captured.
//     - oob = (addr >= ref_len_in).
//   Stage 2 (edge ending t+1): stage-1 tag moves to stage 2; memory registers dout.
//   Response (cycle t+2): rsp_valid_out[id]=1 for exactly one cycle.
//     - rsp_data_out = oob ? 0 : mem_data_in. rsp_err_out = oob.
//     - When no response is valid, rsp_data_out = 0 and rsp_err_out = 0.
//   No response backpressure: requesters must sink rsp in the strobe cycle.
//   Requester rules: keep req_addr stable while valid & !ready. May drop valid without penalty.
//   enable_in -> 0 mid-stream: no new grants from that cycle. Already-granted requests still respond.
//   mem_addr_out holds its last value when there is no grant.
//   busy_out = |req_valid_in | stage1.valid | stage2.valid.
//   Simultaneous requests from all NUM_REQ: each is served within NUM_REQ cycles (starvation-free).
//   ref_len_in = 0: every request is out of range (err=1, data 0).
// STRUCTURE
//   Package dtw_ref_arb_pkg:
//     - ID_WIDTH function ($clog2).
//     - Pipeline tag struct {valid, id, oob}.
//     - RSP_LATENCY=2.
//   Sub-module dtw_rr_arbiter:
//     - Generic NUM_REQ round-robin.
//     - Inputs req, advance; outputs one-hot gnt and index.
//     - Owns the pointer register.
//   Top level: address mux, range compare, 2-stage tag pipeline, response decode.
// TESTING
//   1. Single request: req0 valid addr=5, mem[5]=0x1234.
//      -> ready0 in the same cycle; rsp_valid[0] 2 cycles later; data=0x1234; err=0.
//   2. All 4 requesters valid continuously, pointer=0.
//      -> grants 0,1,2,3,0,... one per cycle.
//      -> responses arrive in the same order with the matching ids.
//   3. req1 and req3 valid after a grant to 1.
//      -> next grant goes to 3, then 1 (pointer wraps correctly).
//   4. ref_len_in=100, req2 addr=100.
//      -> rsp_valid[2] with data=0, err=1. Addr=99 returns mem[99] with err=0.
//   5. Grant in cycle t, enable_in=0 in t+1, requests still held.
//      -> t's response is delivered; no ready until enable returns; busy_out stays 1.
//   6. Assert rst_in asynchronously with 2 responses in flight.
//      -> all outputs 0 immediately; no rsp strobe after release; first grant goes to requester 0.

Source files
------------

// File: rtl/dtw_ref_arb_pkg.sv
// rtl/dtw_ref_arb_pkg.sv - shared types and constants for the DTW reference read arbiter
package dtw_ref_arb_pkg;

  localparam int RSP_LATENCY  = 2;
  localparam int MAX_ID_WIDTH = 4;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Tag carried alongside the memory read so the response can be routed back.
  typedef struct packed {
    logic                    valid;
    logic [MAX_ID_WIDTH-1:0] id;
    logic                    oob;
  } pipe_tag_t;

endpackage

// File: rtl/dtw_rr_arbiter.sv
// rtl/dtw_rr_arbiter.sv - generic round-robin arbiter with its own priority pointer
module dtw_rr_arbiter
  import dtw_ref_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                advance_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                found;
  int                  j;

  // Circular search starting at the pointer; first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_WIDTH'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (int'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dtw_ref_rd_arbiter.sv
// rtl/dtw_ref_rd_arbiter.sv - shares the reference memory read port among DTW cores
module dtw_ref_rd_arbiter
  import dtw_ref_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int ID_WIDTH         = id_width(NUM_REQ)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                enable_in,
  input  logic [REFMEM_PTR_WIDTH-1:0]         ref_len_in,
  input  logic [NUM_REQ-1:0]                  req_valid_in,
  input  logic [NUM_REQ*REFMEM_PTR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]                  req_ready_out,
  output logic [NUM_REQ-1:0]                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0]               rsp_data_out,
  output logic                                rsp_err_out,
  output logic [REFMEM_PTR_WIDTH-1:0]         mem_addr_out,
  input  logic [DATA_WIDTH-1:0]               mem_data_in,
  output logic                                busy_out,
  output logic [ID_WIDTH-1:0]                 dbg_grant_out
);

  logic [NUM_REQ-1:0]          req_masked;
  logic [NUM_REQ-1:0]          gnt;
  logic [ID_WIDTH-1:0]         gnt_idx;
  logic                        gnt_any;
  logic [REFMEM_PTR_WIDTH-1:0] gnt_addr;
  logic                        gnt_oob;

  pipe_tag_t                   s1_d, s1_q, s2_q;
  logic [REFMEM_PTR_WIDTH-1:0] mem_addr_q;
  logic [ID_WIDTH-1:0]         dbg_grant_q;

  // Reset also masks requests so the grant outputs drop the instant reset asserts.
  assign req_masked = req_valid_in & {NUM_REQ{enable_in & ~rst_in}};
  assign gnt_any    = |gnt;

  dtw_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .req_i     (req_masked),
    .advance_i (gnt_any),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );

  always_comb begin
    gnt_addr   = req_addr_in[int'(gnt_idx)*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];
    gnt_oob    = (gnt_addr >= ref_len_in);
    s1_d       = '0;
    s1_d.valid = gnt_any;
    s1_d.id    = MAX_ID_WIDTH'(gnt_idx);
    s1_d.oob   = gnt_oob;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_q        <= '0;
      s2_q        <= '0;
      mem_addr_q  <= '0;
      dbg_grant_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
      if (gnt_any) begin
        mem_addr_q  <= gnt_addr;
        dbg_grant_q <= gnt_idx;
      end
    end
  end

  // Stage-2 tag lines up with the memory's registered read data.
  always_comb begin
    rsp_valid_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_out[i] = s2_q.valid && (s2_q.id == MAX_ID_WIDTH'(i));
    end
  end

  assign rsp_data_out  = (s2_q.valid && !s2_q.oob) ? mem_data_in : '0;
  assign rsp_err_out   = s2_q.valid & s2_q.oob;
  assign req_ready_out = gnt;
  assign mem_addr_out  = mem_addr_q;
  assign dbg_grant_out = dbg_grant_q;
  assign busy_out      = ~rst_in & ((|req_valid_in) | s1_q.valid | s2_q.valid);

endmodule
